dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 34 +++
 rtl/dmem_arbiter_if.sv | 68 ++++++
 rtl/dmem_arb_grant.sv | 48 ++++
 rtl/dmem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the DataMemory two-port arbiter.
//
//   Contents
//     state_e      sequencer states: IDLE -> ACCESS -> (WAIT, reads) -> RESP
//     PORT_CORE    port index of the core load/store unit
//     PORT_LOADER  port index of the loader/debug master
//     RW_WRITE     value of an RW bit meaning "write"
//     RW_READ      value of an RW bit meaning "read"
//     lat_load()   start value of the read-latency counter for a given latency
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic PORT_CORE   = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // The counter starts at MEM_LAT-1 and counts down to zero, so a latency
   // of 1..4 always fits in two bits without wrapping.
   function automatic logic [1:0] lat_load(input int mem_lat);
      return 2'(mem_lat - 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports and the DataMemory side of the arbiter.
//
//   Parameters
//     AW   address width
//     DW   data width
//
//   Signals (per port N = 0 core, 1 loader)
//     reqN_valid / reqN_rw / reqN_addr / reqN_wdata   request from master
//     reqN_ready                                      request accepted
//     rspN_valid / rspN_rdata                         one-cycle response
//   Memory side
//     mem_EN / mem_RW / mem_ADDr / mem_Din            towards DataMemory
//     mem_Dout                                        read data from DataMemory
//
//   Modports
//     slave  : the arbiter
//     master : the environment (requesters plus the memory itself)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
);

   logic          req0_valid;
   logic          req0_rw;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req0_ready;
   logic          rsp0_valid;
   logic [DW-1:0] rsp0_rdata;

   logic          req1_valid;
   logic          req1_rw;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          req1_ready;
   logic          rsp1_valid;
   logic [DW-1:0] rsp1_rdata;

   logic          mem_EN;
   logic          mem_RW;
   logic [AW-1:0] mem_ADDr;
   logic [DW-1:0] mem_Din;
   logic [DW-1:0] mem_Dout;

   modport slave (
      input  req0_valid, req0_rw, req0_addr, req0_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_valid, req1_rw, req1_addr, req1_wdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output mem_EN, mem_RW, mem_ADDr, mem_Din,
      input  mem_Dout
   );

   modport master (
      output req0_valid, req0_rw, req0_addr, req0_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      output req1_valid, req1_rw, req1_addr, req1_wdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  mem_EN, mem_RW, mem_ADDr, mem_Din,
      output mem_Dout
   );

endinterface

// File: rtl/dmem_arb_grant.sv
// -----------------------------------------------------------------------------
// dmem_arb_grant
//   Combinational grant between the two requesters. A grant is only ever
//   given to a port whose valid is high, and at most one grant is high.
//
//   Configuration macro: DMEM_ARB_RR_EN
//     defined   : on a tie the port that did NOT win last time is granted;
//                 the rr_last input exists only in this build.
//     undefined : fixed priority, port 0 (core) wins every tie.
//
//   Ports
//     valid0, valid1   request present on port 0 / port 1
//     rr_last          port of the most recent handshake (RR build only)
//     gnt0, gnt1       grant to port 0 / port 1
// -----------------------------------------------------------------------------
module dmem_arb_grant
   import dmem_arb_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
`ifdef DMEM_ARB_RR_EN
   input  logic rr_last,
`endif
   output logic gnt0,
   output logic gnt1
);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (valid0 && valid1) begin
`ifdef DMEM_ARB_RR_EN
         if (rr_last == PORT_CORE) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
`else
         gnt0 = 1'b1;
`endif
      end else begin
         // A lone requester is granted straight away, no idle bubble.
         gnt0 = valid0;
         gnt1 = valid1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter/sequencer in front of the single-port DataMemory.
//   Port 0 is the core load/store unit, port 1 the loader/debug master.
//   One request is serviced at a time: the accepted request is latched, the
//   memory is enabled for exactly one cycle, reads wait out MEM_LAT cycles,
//   and the result is returned on a one-cycle response pulse to the port
//   that issued it.
//
//   Timing (handshake in cycle T)
//     mem_EN high in T+1; write response in T+2; read response in T+2+MEM_LAT;
//     ready may rise again in the cycle after the response.
//
//   Parameters
//     AW       address width
//     DW       data width
//     MEM_LAT  cycles from the enable edge until mem_Dout is valid (1..4)
//
//   Ports
//     CLK   system clock, rising edge
//     RST   synchronous active-high reset; abandons any transaction in flight
//     bus   dmem_arbiter_if.slave: both request/response ports and the
//           DataMemory signals
//
//   Configuration macro: DMEM_ARB_RR_EN
//     defined   : round-robin on ties, tracked by rr_last (reset to 1 so
//                 the first tie goes to the core)
//     undefined : fixed priority, core always wins, no rr_last state
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          CLK,
   input  logic          RST,
   dmem_arbiter_if.slave bus
);

   localparam logic [1:0] LAT_LOAD = lat_load(MEM_LAT);

   state_e        state_q,   state_d;
   logic [1:0]    lat_cnt_q, lat_cnt_d;
   logic          port_q,    port_d;
   logic          rw_q,      rw_d;
   logic [AW-1:0] addr_q,    addr_d;
   logic [DW-1:0] wdata_q,   wdata_d;
   logic [DW-1:0] rdata_q [2];
   logic [DW-1:0] rdata_d [2];
`ifdef DMEM_ARB_RR_EN
   logic          rr_last_q, rr_last_d;
`endif

   logic gnt0;
   logic gnt1;
   logic ready0;
   logic ready1;
   logic hs0;
   logic hs1;
   logic rsp_valid [2];

   // -------------------------------------------------------------------------
   // Grant
   // -------------------------------------------------------------------------
   dmem_arb_grant u_grant (
      .valid0  (bus.req0_valid),
      .valid1  (bus.req1_valid),
`ifdef DMEM_ARB_RR_EN
      .rr_last (rr_last_q),
`endif
      .gnt0    (gnt0),
      .gnt1    (gnt1)
   );

   // Ready is offered only while idle and never while reset is asserted, so
   // nothing can be accepted in a cycle whose state is about to be discarded.
   assign ready0 = (state_q == IDLE) && !RST && gnt0;
   assign ready1 = (state_q == IDLE) && !RST && gnt1;
   assign hs0    = bus.req0_valid && ready0;
   assign hs1    = bus.req1_valid && ready1;

   // -------------------------------------------------------------------------
   // Next-state and latch logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      port_d    = port_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
`ifdef DMEM_ARB_RR_EN
      rr_last_d = rr_last_q;
`endif

      case (state_q)
         IDLE: begin
            if (hs0 || hs1) begin
               port_d  = hs1 ? PORT_LOADER : PORT_CORE;
               rw_d    = hs1 ? bus.req1_rw    : bus.req0_rw;
               addr_d  = hs1 ? bus.req1_addr  : bus.req0_addr;
               wdata_d = hs1 ? bus.req1_wdata : bus.req0_wdata;
`ifdef DMEM_ARB_RR_EN
               rr_last_d = hs1 ? PORT_LOADER : PORT_CORE;
`endif
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            if (rw_q == RW_WRITE) begin
               // Writes answer with zero data on the issuing port.
               rdata_d[port_q] = '0;
               state_d         = RESP;
            end else begin
               lat_cnt_d = LAT_LOAD;
               state_d   = WAIT;
            end
         end

         WAIT: begin
            if (lat_cnt_q == 2'd0) begin
               rdata_d[port_q] = bus.mem_Dout;
               state_d         = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         lat_cnt_q <= 2'd0;
         port_q    <= PORT_CORE;
         rw_q      <= RW_READ;
         addr_q    <= '0;
         wdata_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            rdata_q[i] <= '0;
         end
`ifdef DMEM_ARB_RR_EN
         rr_last_q <= PORT_LOADER;
`endif
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         port_q    <= port_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
`ifdef DMEM_ARB_RR_EN
         rr_last_q <= rr_last_d;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // The memory address/data/RW come straight from the request latches, so
   // they naturally hold their last value whenever mem_EN is low.
   assign bus.mem_EN   = (state_q == ACCESS);
   assign bus.mem_RW   = rw_q;
   assign bus.mem_ADDr = addr_q;
   assign bus.mem_Din  = wdata_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_q == RESP) && (port_q == 1'(gi));
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rsp0_valid = rsp_valid[0];
   assign bus.rsp1_valid = rsp_valid[1];
   assign bus.rsp0_rdata = rdata_q[0];
   assign bus.rsp1_rdata = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiter instances (MEM_LAT = 1 and MEM_LAT = 3), each with its own
//   requesters and memory model (reads return addr*2). A transaction-level
//   reference predicts, from the request stream alone, when each port is
//   ready, when the memory is enabled and with what, and when and with what
//   data each response pulse appears. Every output is compared every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

   dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
   dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

   // ---------------- requester stimulus, indexed [instance][port] ----------
   logic          v     [2][2];
   logic          rw    [2][2];
   logic [31:0]   addr  [2][2];
   logic [31:0]   wdata [2][2];
   logic          hs_seen [2][2];

   // ---------------- observed DUT outputs ----------------------------------
   logic          obs_ready [2][2];
   logic          obs_rsp_v [2][2];
   logic [31:0]   obs_rdata [2][2];
   logic          obs_en    [2];
   logic          obs_rw    [2];
   logic [31:0]   obs_addr  [2];
   logic [31:0]   obs_din   [2];

   assign bus_a.req0_valid = v[0][0];  assign bus_a.req1_valid = v[0][1];
   assign bus_a.req0_rw    = rw[0][0]; assign bus_a.req1_rw    = rw[0][1];
   assign bus_a.req0_addr  = addr[0][0];  assign bus_a.req1_addr  = addr[0][1];
   assign bus_a.req0_wdata = wdata[0][0]; assign bus_a.req1_wdata = wdata[0][1];
   assign bus_b.req0_valid = v[1][0];  assign bus_b.req1_valid = v[1][1];
   assign bus_b.req0_rw    = rw[1][0]; assign bus_b.req1_rw    = rw[1][1];
   assign bus_b.req0_addr  = addr[1][0];  assign bus_b.req1_addr  = addr[1][1];
   assign bus_b.req0_wdata = wdata[1][0]; assign bus_b.req1_wdata = wdata[1][1];

   assign obs_ready[0][0] = bus_a.req0_ready;  assign obs_ready[0][1] = bus_a.req1_ready;
   assign obs_rsp_v[0][0] = bus_a.rsp0_valid;  assign obs_rsp_v[0][1] = bus_a.rsp1_valid;
   assign obs_rdata[0][0] = bus_a.rsp0_rdata;  assign obs_rdata[0][1] = bus_a.rsp1_rdata;
   assign obs_ready[1][0] = bus_b.req0_ready;  assign obs_ready[1][1] = bus_b.req1_ready;
   assign obs_rsp_v[1][0] = bus_b.rsp0_valid;  assign obs_rsp_v[1][1] = bus_b.rsp1_valid;
   assign obs_rdata[1][0] = bus_b.rsp0_rdata;  assign obs_rdata[1][1] = bus_b.rsp1_rdata;
   assign obs_en[0]   = bus_a.mem_EN;   assign obs_en[1]   = bus_b.mem_EN;
   assign obs_rw[0]   = bus_a.mem_RW;   assign obs_rw[1]   = bus_b.mem_RW;
   assign obs_addr[0] = bus_a.mem_ADDr; assign obs_addr[1] = bus_b.mem_ADDr;
   assign obs_din[0]  = bus_a.mem_Din;  assign obs_din[1]  = bus_b.mem_Din;

   // ---------------- memory models: read data = addr*2, LAT cycles late ----
   logic [31:0] dl [2][1:4];
   always @(posedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         if (obs_en[k] && !obs_rw[k]) dl[k][1] <= obs_addr[k] << 1;
         for (int i = 2; i <= 4; i++) dl[k][i] <= dl[k][i-1];
      end
   end
   assign bus_a.mem_Dout = dl[0][LAT_A];
   assign bus_b.mem_Dout = dl[1][LAT_B];

   // ---------------- checking ----------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic run_chk = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model (one outstanding transaction) ---------
   int          en_cyc  [2];
   int          rsp_cyc [2];
   logic        m_port  [2];
   logic        m_rw    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_din   [2];
   logic [31:0] m_rdata [2];
   logic        last_rw   [2];
   logic [31:0] last_addr [2];
   logic [31:0] last_din  [2];
   logic [31:0] hold_rdata [2][2];
   logic        rr_last [2];

   task automatic model_reset(input int k);
      en_cyc[k]  = -1;
      rsp_cyc[k] = -1;
      last_rw[k] = 1'b0;
      last_addr[k] = '0;
      last_din[k]  = '0;
      hold_rdata[k][0] = '0;
      hold_rdata[k][1] = '0;
      rr_last[k] = 1'b1;
   endtask

   task automatic model_cycle(input int k);
      int   g;
      int   lat;
      logic free;
      lat  = (k == 0) ? LAT_A : LAT_B;
      free = (cyc > rsp_cyc[k]);

      if (cyc == en_cyc[k]) begin
         last_rw[k]   = m_rw[k];
         last_addr[k] = m_addr[k];
         last_din[k]  = m_din[k];
      end
      if (cyc == rsp_cyc[k]) begin
         hold_rdata[k][m_port[k]] = m_rdata[k];
         $display("inst %0d port %0d %s addr=%h rdata=%h cycle %0d", k, m_port[k],
                  m_rw[k] ? "WR" : "RD", m_addr[k], m_rdata[k], cyc);
      end

      check($sformatf("mem_EN[%0d]", k),   32'(obs_en[k]), 32'(cyc == en_cyc[k]));
      check($sformatf("mem_RW[%0d]", k),   32'(obs_rw[k]), 32'(last_rw[k]));
      check($sformatf("mem_ADDr[%0d]", k), obs_addr[k], last_addr[k]);
      check($sformatf("mem_Din[%0d]", k),  obs_din[k],  last_din[k]);

      // Grant rule: both valid -> core (or the port that did not win last,
      // in round-robin builds); otherwise the single valid port.
      g = -1;
      if (v[k][0] && v[k][1]) begin
`ifdef DMEM_ARB_RR_EN
         g = rr_last[k] ? 0 : 1;
`else
         g = 0;
`endif
      end else if (v[k][0]) begin
         g = 0;
      end else if (v[k][1]) begin
         g = 1;
      end

      for (int p = 0; p < 2; p++) begin
         check($sformatf("ready%0d[%0d]", p, k), 32'(obs_ready[k][p]),
               32'(free && !RST && g == p));
         check($sformatf("rsp%0d_valid[%0d]", p, k), 32'(obs_rsp_v[k][p]),
               32'(cyc == rsp_cyc[k] && m_port[k] == 1'(p)));
         check($sformatf("rsp%0d_rdata[%0d]", p, k), obs_rdata[k][p], hold_rdata[k][p]);
         hs_seen[k][p] = v[k][p] && obs_ready[k][p];
      end

      if (RST) begin
         model_reset(k);
      end else if (free && g >= 0) begin
         m_port[k]  = 1'(g);
         m_rw[k]    = rw[k][g];
         m_addr[k]  = addr[k][g];
         m_din[k]   = wdata[k][g];
         m_rdata[k] = (rw[k][g] == RW_WRITE) ? 32'd0 : addr[k][g] * 2;
         en_cyc[k]  = cyc + 1;
         rsp_cyc[k] = cyc + 2 + ((rw[k][g] == RW_WRITE) ? 0 : lat);
         rr_last[k] = 1'(g);
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         if (run_chk) begin
            for (int k = 0; k < 2; k++) model_cycle(k);
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------------------------------------
   logic rand_on = 1'b0;
   logic sticky  = 1'b0;

   task automatic clear_all();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) v[k][p] = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (hs_seen[k][p] && !sticky) v[k][p] = 1'b0;
            if (rand_on) begin
               if (!v[k][p]) begin
                  if ($urandom_range(0, 99) < 35) begin
                     v[k][p]     = 1'b1;
                     rw[k][p]    = 1'($urandom_range(0, 1));
                     addr[k][p]  = 32'($urandom_range(0, 255));
                     wdata[k][p] = $urandom;
                  end
               end else if (!hs_seen[k][p] && $urandom_range(0, 99) < 6) begin
                  v[k][p] = 1'b0;  // legal withdrawal before ready
               end
            end
         end
      end
   endtask

   task automatic set_req(input int k, input int p, input logic r,
                          input logic [31:0] a, input logic [31:0] d);
      v[k][p]     = 1'b1;
      rw[k][p]    = r;
      addr[k][p]  = a;
      wdata[k][p] = d;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         m_port[k] = 1'b0; m_rw[k] = 1'b0;
         m_addr[k] = '0; m_din[k] = '0; m_rdata[k] = '0;
         for (int p = 0; p < 2; p++) begin
            v[k][p] = 1'b0; rw[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0;
            hs_seen[k][p] = 1'b0;
         end
      end
      RST = 1'b1;
      @(posedge CLK);
      #1 run_chk = 1'b1;          // reset-state values checked from here on
      step(); step();
      RST = 1'b0;

      // Write on port 0, then read on port 1 (both instances).
      step();
      set_req(0, 0, RW_WRITE, 32'd3, 32'd24);
      set_req(1, 0, RW_WRITE, 32'd3, 32'd24);
      repeat (4) step();
      set_req(0, 1, RW_READ, 32'd3, 32'd0);
      set_req(1, 1, RW_READ, 32'd3, 32'd0);
      repeat (7) step();

      // Both ports requesting continuously.
      sticky = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_req(k, 0, RW_READ, 32'd4, 32'd0);
         set_req(k, 1, RW_READ, 32'd5, 32'd0);
      end
      repeat (24) step();
      sticky = 1'b0;
      clear_all();
      repeat (8) step();

      // Single read, latency visible on the MEM_LAT=3 instance.
      set_req(0, 0, RW_READ, 32'd7, 32'd0);
      set_req(1, 0, RW_READ, 32'd7, 32'd0);
      repeat (8) step();

      // Reset in the cycle after ACCESS of a read, then a normal request.
      set_req(0, 0, RW_READ, 32'd8, 32'd0);
      set_req(1, 0, RW_READ, 32'd8, 32'd0);
      step();
      step();
      RST = 1'b1;
      clear_all();
      step();
      RST = 1'b0;
      repeat (3) step();
      set_req(0, 0, RW_WRITE, 32'd9, 32'd77);
      set_req(1, 1, RW_READ, 32'd9, 32'd0);
      repeat (7) step();

      // One-cycle pulse on port 0 while busy: must never be granted.
      set_req(0, 1, RW_READ, 32'd9, 32'd0);
      step();
      set_req(0, 0, RW_READ, 32'd10, 32'd0);
      step();
      v[0][0] = 1'b0;
      repeat (6) step();

      // Randomised traffic with occasional withdrawals.
      rand_on = 1'b1;
      repeat (3000) step();
      rand_on = 1'b0;
      clear_all();
      repeat (10) step();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
